// File: rtl/load_align_ext.sv
// Load-data aligner/extender for the MEM->WB boundary: picks a byte/half/word/dword field
// out of the raw beat, extends it, flags misalignment, and registers it behind a 1-entry skid.
module load_align_ext #(
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 5,
    parameter  int CNT_W  = 8,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_sext,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_misalign,
    output logic [CNT_W-1:0]  misalign_cnt
);

    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_result;
    logic [6:0]        w_fw;
    logic              w_msb;
    logic              w_misalign;
    logic              w_accept;
    logic              w_load;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_out_mis;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [TAG_W-1:0]  r_skid_tag;
    logic              r_skid_mis;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_cnt;

    // Shift the addressed byte down to bit 0, then mask to the field width; a field as wide
    // as the beat gets an all-ones mask because the shifted-in ones fall off the top.
    always_comb begin
        w_shift    = in_data >> {in_off, 3'b000};
        w_fw       = 7'd8;
        w_msb      = w_shift[7];
        w_misalign = 1'b0;
        case (in_size)
            2'b00: w_fw = 7'd8;
            2'b01: begin
                w_fw       = 7'd16;
                w_msb      = w_shift[15];
                w_misalign = in_off[0];
            end
            2'b10: begin
                w_fw       = 7'd32;
                w_msb      = w_shift[31];
                w_misalign = (in_off[1:0] != 2'b00);
            end
            default: begin
                w_fw       = 7'd64;
                w_msb      = w_shift[DATA_W-1];
                w_misalign = (DATA_W == 32) || (in_off != '0);
            end
        endcase
        w_mask   = ~({DATA_W{1'b1}} << w_fw);
        w_result = w_misalign ? '0
                 : ((w_shift & w_mask) | ((in_sext & w_msb) ? ~w_mask : '0));
    end

    assign w_accept = in_valid & r_in_ready;
    assign w_load   = ~r_out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_tag    <= '0;
            r_out_mis    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_tag   <= '0;
            r_skid_mis   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_cnt        <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_load) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_tag    <= r_skid_tag;
                    r_out_mis    <= r_skid_mis;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_result;
                    r_out_tag   <= in_tag;
                    r_out_mis   <= w_misalign;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                // Output is stalled: park the request and close the input next cycle.
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_result;
                r_skid_tag   <= in_tag;
                r_skid_mis   <= w_misalign;
                r_in_ready   <= 1'b0;
            end
            if (w_accept && w_misalign && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_tag      = r_out_tag;
    assign out_misalign = r_out_mis;
    assign misalign_cnt = r_cnt;

endmodule

// File: tb/tb_load_align_ext.sv
// Bench for load_align_ext: queue scoreboard against an arithmetic reference model on a 32-bit
// instance, plus a 64-bit instance with a 2-bit counter for dword and saturation behaviour.
module tb_load_align_ext;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        flush, in_valid, in_ready, in_sext, out_valid, out_ready, out_misalign;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_off, in_size;
    logic [4:0]  in_tag, out_tag;
    logic [7:0]  misalign_cnt;

    // 64-bit instance
    logic        b_flush, b_in_valid, b_in_ready, b_in_sext, b_out_valid, b_out_ready, b_out_misalign;
    logic [63:0] b_in_data, b_out_data;
    logic [2:0]  b_in_off;
    logic [1:0]  b_in_size, b_misalign_cnt;
    logic [4:0]  b_in_tag, b_out_tag;

    load_align_ext #(.DATA_W(32), .TAG_W(5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_off(in_off),
        .in_size(in_size), .in_sext(in_sext), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_misalign(out_misalign), .misalign_cnt(misalign_cnt)
    );

    load_align_ext #(.DATA_W(64), .TAG_W(5), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_off(b_in_off),
        .in_size(b_in_size), .in_sext(b_in_sext), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag),
        .out_misalign(b_out_misalign), .misalign_cnt(b_misalign_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: field of 2^size bytes at byte offset off, extended to dw bits.
    // Returns {misalign, result}.
    function automatic logic [64:0] ref_load(input logic [63:0] data, input int off,
                                             input int size, input bit sext, input int dw);
        int nbytes = 1 << size;
        logic [127:0] field;
        logic [127:0] res;
        if (nbytes > dw / 8 || (off % nbytes) != 0) return {1'b1, 64'd0};
        field = ({64'd0, data} >> (8 * off)) % (128'd1 << (8 * nbytes));
        if (sext && field >= (128'd1 << (8 * nbytes - 1)))
            res = field + ((128'd1 << dw) - (128'd1 << (8 * nbytes)));
        else
            res = field;
        return {1'b0, res[63:0]};
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   cnt_model = 0;

    // Monitor: items in flight equal the scoreboard depth, so occupancy predicts
    // out_valid and in_ready; output handshakes pop, input handshakes push.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            cnt_model = 0;
        end else begin
            chk("out_valid_vs_occupancy", 64'(out_valid), 64'(sb.size() > 0));
            chk("in_ready_vs_occupancy", 64'(in_ready), 64'(sb.size() < 2));
            chk("misalign_cnt", 64'(misalign_cnt), 64'(cnt_model));
            if (out_valid && out_ready && !flush && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                $display("txn tag=%0d data=%h mis=%0d", out_tag, out_data, out_misalign);
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_misalign", 64'(out_misalign), 64'(e.mis));
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                logic [64:0] r;
                exp_t        e;
                r = ref_load({32'd0, in_data}, int'(in_off), int'(in_size), in_sext, 32);
                e.data = r[31:0];
                e.tag  = in_tag;
                e.mis  = r[64];
                sb.push_back(e);
                if (r[64] && cnt_model < 255) cnt_model++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                         input logic sx, input logic [4:0] tg);
        in_valid = 1'b1;
        in_data  = d;
        in_off   = off;
        in_size  = sz;
        in_sext  = sx;
        in_tag   = tg;
    endtask

    // Hold the request until it is handshaked, bounded.
    task automatic send(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                        input logic sx, input logic [4:0] tg);
        logic acc;
        acc = 1'b0;
        drive(d, off, sz, sx, tg);
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            step();
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic b_drive(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                           input logic sx, input logic [4:0] tg);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_off   = off;
        b_in_size  = sz;
        b_in_sext  = sx;
        b_in_tag   = tg;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] r;
        int          bcnt;
        int          cnt_before;

        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_data = '0; in_off = '0; in_size = '0;
        in_sext = 1'b0; in_tag = '0; out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_off = '0; b_in_size = '0;
        b_in_sext = 1'b0; b_in_tag = '0; b_out_ready = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_misalign", 64'(out_misalign), 64'd0);
        chk("rst_cnt", 64'(misalign_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        step();

        // Byte sign-extend, half zero/sign-extend
        send(32'h1234_80FF, 2'd1, 2'b00, 1'b1, 5'd1);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_byte_sext", 64'(out_data), 64'hFFFF_FF80);
        send(32'h8001_0000, 2'd2, 2'b01, 1'b0, 5'd2);
        chk("t2_half_zext", 64'(out_data), 64'h0000_8001);
        send(32'h8001_0000, 2'd2, 2'b01, 1'b1, 5'd3);
        chk("t2_half_sext", 64'(out_data), 64'hFFFF_8001);

        // Misaligned half and word
        send(32'hDEAD_BEEF, 2'd1, 2'b01, 1'b1, 5'd4);
        chk("t3_half_mis", 64'(out_misalign), 64'd1);
        chk("t3_half_data", 64'(out_data), 64'd0);
        send(32'hDEAD_BEEF, 2'd2, 2'b10, 1'b0, 5'd5);
        chk("t3_word_mis", 64'(out_misalign), 64'd1);
        chk("t3_cnt", 64'(misalign_cnt), 64'd2);
        send(32'hCAFE_F00D, 2'd0, 2'b10, 1'b1, 5'd6);
        chk("t3_word_pass", 64'(out_data), 64'hCAFE_F00D);
        step();

        // Backpressure: tags 1,2 taken, 3 refused until the stall clears
        out_ready = 1'b0;
        drive(32'h0000_0011, 2'd0, 2'b00, 1'b0, 5'd1);
        step();
        drive(32'h0000_0022, 2'd0, 2'b00, 1'b0, 5'd2);
        step();
        chk("t4_in_ready_low", 64'(in_ready), 64'd0);
        drive(32'h0000_0033, 2'd0, 2'b00, 1'b0, 5'd3);
        step();
        step();
        chk("t4_in_ready_held", 64'(in_ready), 64'd0);
        chk("t4_out_tag_held", 64'(out_tag), 64'd1);
        chk("t4_out_data_held", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        send(32'h0000_0033, 2'd0, 2'b00, 1'b0, 5'd3);
        repeat (3) step();

        // Flush with skid full, then flush discarding a same-cycle handshake
        out_ready = 1'b0;
        drive(32'h0000_0077, 2'd0, 2'b00, 1'b0, 5'd7);
        step();
        drive(32'h0000_0088, 2'd0, 2'b00, 1'b0, 5'd8);
        step();
        drive(32'h0000_0099, 2'd0, 2'b00, 1'b0, 5'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        cnt_before = int'(misalign_cnt);
        drive(32'h1111_1111, 2'd1, 2'b10, 1'b0, 5'd10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_discard_valid", 64'(out_valid), 64'd0);
        chk("t5_discard_cnt", 64'(misalign_cnt), 64'(cnt_before));
        out_ready = 1'b1;
        repeat (3) step();

        // Randomized traffic with random stalls and occasional flush
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_off    = 2'($urandom_range(0, 3));
            in_size   = 2'($urandom_range(0, 3));
            in_sext   = 1'($urandom_range(0, 1));
            in_tag    = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);

        // 64-bit instance: dword passthrough, counter saturation, random aligned traffic
        b_drive(64'h8000_0000_0000_0001, 3'd0, 2'b11, 1'b1, 5'd1);
        step();
        chk("b_dword_data", b_out_data, 64'h8000_0000_0000_0001);
        chk("b_dword_mis", 64'(b_out_misalign), 64'd0);
        bcnt = 0;
        for (int i = 0; i < 5; i++) begin
            b_drive(64'h0123_4567_89AB_CDEF, 3'd1, 2'b01, 1'b0, 5'(i));
            step();
            if (bcnt < 3) bcnt++;
            chk("b_sat_cnt", 64'(b_misalign_cnt), 64'(bcnt));
        end
        chk("b_sat_final", 64'(b_misalign_cnt), 64'd3);
        for (int i = 0; i < 60; i++) begin
            b_drive({$urandom, $urandom}, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            r = ref_load(b_in_data, int'(b_in_off), int'(b_in_size), b_in_sext, 64);
            step();
            $display("txn b tag=%0d data=%h mis=%0d", b_out_tag, b_out_data, b_out_misalign);
            chk("b_rand_valid", 64'(b_out_valid), 64'd1);
            chk("b_rand_data", b_out_data, r[63:0]);
            chk("b_rand_mis", 64'(b_out_misalign), 64'(r[64]));
            chk("b_rand_tag", 64'(b_out_tag), 64'(b_in_tag));
        end
        b_in_valid = 1'b0;
        step();

        // Async reset between clock edges while output and skid are full
        out_ready = 1'b0;
        drive(32'h0000_00A5, 2'd0, 2'b00, 1'b0, 5'd12);
        step();
        drive(32'h0000_005A, 2'd0, 2'b00, 1'b0, 5'd13);
        step();
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_out_data", 64'(out_data), 64'd0);
        chk("t6_out_tag", 64'(out_tag), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_cnt", 64'(misalign_cnt), 64'd0);
        chk("t6_b_cnt", 64'(b_misalign_cnt), 64'd0);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
